// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared types and limits for the serializer and detector
package serial_pkg;

    // Legal parameter range for the serializer.
    localparam int WIDTH_MIN = 2;
    localparam int GAP_MAX   = 15;

    // Serializer FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Downstream bit-sequence detector states (1001 pattern tracker).
    typedef enum logic [2:0] {
        D_IDLE  = 3'd0,
        D_S1    = 3'd1,
        D_S10   = 3'd2,
        D_S100  = 3'd3,
        D_S1001 = 3'd4
    } det_state_t;

    // Bits needed to hold a counter that counts down from n-1; never below 1.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word input handshake and serial bit output bundle
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             bit_o;
    logic             bit_valid_o;
    logic             last_o;
    logic             busy_o;

    // Word producer side.
    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  bit_o,
        input  bit_valid_o,
        input  last_o,
        input  busy_o
    );

    // Serializer side.
    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output bit_o,
        output bit_valid_o,
        output last_o,
        output busy_o
    );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to one-bit-per-clock serializer with optional idle gap
module bit_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    bit_serializer_if.slave sif
);

    localparam int BW = cnt_bits(WIDTH);
    localparam int GW = (GAP == 0) ? 1 : $clog2(GAP + 1);

    localparam logic [BW-1:0] BCNT_LOAD = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GCNT_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    // Reject configurations the counters and FSM are not built for.
    if (WIDTH < WIDTH_MIN || GAP > GAP_MAX) begin : g_param_check
        $error("bit_serializer: WIDTH must be >= 2 and GAP must be 0..15");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_shifted;
    logic [BW-1:0]    bcnt_q;
    logic [GW-1:0]    gcnt_q;
    logic             out_bit;
    logic             bit_last;
    logic             ready;
    logic             accept;

    // The output end of the shift register and the shift direction toward it.
    if (MSB_FIRST != 0) begin : g_msb
        assign out_bit       = shreg_q[WIDTH-1];
        assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
        assign out_bit       = shreg_q[0];
        assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end

    assign bit_last = (state_q == S_SHIFT) && (bcnt_q == '0);
    assign accept   = sif.valid_i && ready;

    // State, shift register and counters; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        shreg_q <= sif.data_i;
                        bcnt_q  <= BCNT_LOAD;
                    end
                end
                S_SHIFT: begin
                    if (bcnt_q == '0) begin
                        if (accept) begin
                            shreg_q <= sif.data_i;
                            bcnt_q  <= BCNT_LOAD;
                        end else begin
                            shreg_q <= '0;
                            gcnt_q  <= GCNT_LOAD;
                        end
                    end else begin
                        shreg_q <= shreg_shifted;
                        bcnt_q  <= bcnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt_q != '0) begin
                        gcnt_q <= gcnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state selection; a last bit with an accept chains straight into the next word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bcnt_q == '0) begin
                    if (accept) begin
                        state_d = S_SHIFT;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        ready           = 1'b0;
        sif.bit_o       = 1'b0;
        sif.bit_valid_o = 1'b0;
        sif.last_o      = 1'b0;
        sif.busy_o      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_SHIFT: begin
                sif.busy_o      = 1'b1;
                sif.bit_valid_o = 1'b1;
                sif.bit_o       = out_bit;
                sif.last_o      = bit_last;
                ready           = bit_last && (GAP == 0);
            end
            S_GAP: begin
                sif.busy_o = 1'b1;
            end
            default: ;
        endcase
        sif.ready_o = ready;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer
module tb_bit_serializer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bit_serializer_if #(.WIDTH(8)) sif0 ();
    bit_serializer_if #(.WIDTH(8)) sif1 ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif0.slave)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] pair;
        logic [7:0]  junk;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sif0.valid_i = 1'b0;
        sif0.data_i  = '0;
        sif1.valid_i = 1'b0;
        sif1.data_i  = '0;

        // Reset values while held in reset.
        step();
        step();
        chk("rst_ready0", sif0.ready_o, 1'b1);
        chk("rst_bv0",    sif0.bit_valid_o, 1'b0);
        chk("rst_bit0",   sif0.bit_o, 1'b0);
        chk("rst_last0",  sif0.last_o, 1'b0);
        chk("rst_busy0",  sif0.busy_o, 1'b0);
        chk("rst_ready1", sif1.ready_o, 1'b1);
        rst_n = 1'b1;

        // Idle after release.
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_ready0", sif0.ready_o, 1'b1);
            chk("idle_bv0",    sif0.bit_valid_o, 1'b0);
            chk("idle_bit0",   sif0.bit_o, 1'b0);
            chk("idle_ready1", sif1.ready_o, 1'b1);
            chk("idle_bv1",    sif1.bit_valid_o, 1'b0);
            chk("idle_bit1",   sif1.bit_o, 1'b0);
        end

        // MSB-first single word 0x90.
        w = 8'h90;
        sif0.valid_i = 1'b1;
        sif0.data_i  = w;
        chk("msb_ready_c0", sif0.ready_o, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step();
            sif0.valid_i = 1'b0;
            chk("msb_bit",  sif0.bit_o, w[8-c]);
            chk("msb_bv",   sif0.bit_valid_o, 1'b1);
            chk("msb_last", sif0.last_o, (c == 8));
            chk("msb_busy", sif0.busy_o, 1'b1);
        end
        step();
        chk("msb_end_bv",   sif0.bit_valid_o, 1'b0);
        chk("msb_end_busy", sif0.busy_o, 1'b0);
        chk("msb_end_rdy",  sif0.ready_o, 1'b1);

        // Back-to-back 0xA5 then 0x3C with junk data held off mid-word.
        pair = 16'hA53C;
        sif0.valid_i = 1'b1;
        sif0.data_i  = 8'hA5;
        chk("b2b_ready_c0", sif0.ready_o, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("b2b_bit",  sif0.bit_o, pair[16-c]);
            chk("b2b_bv",   sif0.bit_valid_o, 1'b1);
            chk("b2b_last", sif0.last_o, (c == 8 || c == 16));
            if (c < 16) begin
                chk("b2b_ready", sif0.ready_o, (c == 8));
            end
            if (c < 8) begin
                junk = 8'($urandom_range(0, 255));
                sif0.data_i = junk;
            end else if (c == 8) begin
                sif0.data_i = 8'h3C;
            end else begin
                sif0.valid_i = 1'b0;
                sif0.data_i  = 8'hFF;
            end
        end
        step();
        chk("b2b_end_bv",   sif0.bit_valid_o, 1'b0);
        chk("b2b_end_busy", sif0.busy_o, 1'b0);

        // Reset mid-word: 0xFF, three bits out, then async reset.
        sif0.valid_i = 1'b1;
        sif0.data_i  = 8'hFF;
        step();
        sif0.valid_i = 1'b0;
        chk("mid_bit1", sif0.bit_o, 1'b1);
        step();
        chk("mid_bit2", sif0.bit_o, 1'b1);
        step();
        chk("mid_bit3", sif0.bit_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", sif0.ready_o, 1'b1);
        chk("mid_rst_bv",    sif0.bit_valid_o, 1'b0);
        chk("mid_rst_bit",   sif0.bit_o, 1'b0);
        chk("mid_rst_last",  sif0.last_o, 1'b0);
        chk("mid_rst_busy",  sif0.busy_o, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        w = 8'h81;
        sif0.valid_i = 1'b1;
        sif0.data_i  = w;
        chk("post_rst_ready", sif0.ready_o, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step();
            sif0.valid_i = 1'b0;
            chk("post_rst_bit",  sif0.bit_o, w[8-c]);
            chk("post_rst_bv",   sif0.bit_valid_o, 1'b1);
            chk("post_rst_last", sif0.last_o, (c == 8));
        end
        step();

        // LSB-first with GAP=3: 0x09 then 0x01 held pending.
        w = 8'h09;
        sif1.valid_i = 1'b1;
        sif1.data_i  = w;
        chk("gap_ready_c0", sif1.ready_o, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) begin
                sif1.data_i = 8'h01;
            end
            if (c <= 8) begin
                chk("gap_bit",   sif1.bit_o, w[c-1]);
                chk("gap_bv",    sif1.bit_valid_o, 1'b1);
                chk("gap_last",  sif1.last_o, (c == 8));
                chk("gap_ready", sif1.ready_o, 1'b0);
            end else if (c <= 11) begin
                chk("gap_idle_bv",    sif1.bit_valid_o, 1'b0);
                chk("gap_idle_bit",   sif1.bit_o, 1'b0);
                chk("gap_idle_ready", sif1.ready_o, 1'b0);
                chk("gap_idle_busy",  sif1.busy_o, 1'b1);
            end else begin
                chk("gap_c12_ready", sif1.ready_o, 1'b1);
                chk("gap_c12_busy",  sif1.busy_o, 1'b0);
                chk("gap_c12_bv",    sif1.bit_valid_o, 1'b0);
            end
        end
        w = 8'h01;
        for (int c = 1; c <= 8; c++) begin
            step();
            sif1.valid_i = 1'b0;
            chk("gap2_bit",  sif1.bit_o, w[c-1]);
            chk("gap2_bv",   sif1.bit_valid_o, 1'b1);
            chk("gap2_last", sif1.last_o, (c == 8));
        end
        step();
        chk("gap2_after_bv",   sif1.bit_valid_o, 1'b0);
        chk("gap2_after_busy", sif1.busy_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
